nibble_serial_add_ctrl: RTL
===========================

// Module: nibble_serial_add_ctrl
// PURPOSE
//  Sequencer that runs a wide (4*NIBBLES-bit) addition through one shared 4-bit ripple_adder,
//  one nibble per cycle, LSB nibble first, feeding carry back between nibbles.
//  Sits between a requester (start valid/ready) and a consumer (result valid/ready).
//  Trades throughput for area: one adder slice serves any operand width.
// PARAMETERS
//  NIBBLES  4  operand width in nibbles (>=1); data width W = 4*NIBBLES
// PORTS
//  clk          in   1   single clock, all flops on posedge
//  rst_n        in   1   asynchronous, active-low reset
//  start_valid  in   1   request valid; op_a/op_b/cin sampled on accept
//  start_ready  out  1   block can accept; equals (state==IDLE)
//  op_a         in   W   operand A
//  op_b         in   W   operand B
//  cin          in   1   carry-in to nibble 0
//  res_valid    out  1   sum/cout valid; equals (state==DONE)
//  res_ready    in   1   consumer takes result
//  sum          out  W   registered result, A+B+cin mod 2^W
//  cout         out  1   registered carry out of top nibble
//  busy         out  1   state != IDLE
// BEHAVIOUR
//  Reset (rst_n low, async): state=IDLE, sum=0, cout=0, carry=0, nibble idx=0,
//   operand shift regs=0; hence res_valid=0, busy=0, start_ready=1. No capture while in reset.
//  FSM states IDLE, ADD, DONE:
//   IDLE: start_valid&start_ready at edge -> load a_sh<=op_a, b_sh<=op_b, carry<=cin,
//         idx<=0, sum<=0 -> ADD. Otherwise stay.
//   ADD: adder inputs X=a_sh[3:0], Y=b_sh[3:0], Cin=carry. Each edge: a_sh,b_sh shift
//        right 4; sum <= {S, sum[W-1:4]}; carry<=Co; idx<=idx+1.
//        On edge where idx==NIBBLES-1: cout<=Co -> DONE.
//   DONE: sum/cout held stable. res_ready at edge -> IDLE (sum/cout keep value).
//  Latency: res_valid rises exactly NIBBLES edges after the accepting edge.
//  Min issue interval: NIBBLES+2 cycles (ADD x NIBBLES, DONE x1, IDLE x1); no overlap.
//  start_valid while busy: ignored, start_ready=0; requester must hold request.
//  op_a/op_b/cin changes after accept: no effect on result.
//  res_ready low: DONE held indefinitely, sum/cout stable, start_ready=0.
//  Overflow: sum wraps mod 2^W, lost carry appears on cout; no saturation.
//  NIBBLES==1: single ADD cycle, idx width clog2 rounded up to 1 bit.
//  Reset mid-ADD/DONE: operation aborted, no res_valid, outputs to reset values.
//  Adder is combinational; only sum, cout, carry, shift regs, idx, state are flops.
// STRUCTURE
//  Shared header nibble_add_defs.vh: NIBBLE_W=4, state encodings
//   ST_IDLE=2'd0, ST_ADD=2'd1, ST_DONE=2'd2 (2'd3 unreachable -> recover to IDLE).
//  One sub-module: existing ripple_adder (ports X,Y,S,Co,Cin), instantiated once as u_add.
//  Counter idx width = max(1,$clog2(NIBBLES)).
// TESTING (NIBBLES=4)
//  1. op_a=16'h1234, op_b=16'h4321, cin=0 -> after 4 edges res_valid=1, sum=16'h5555, cout=0.
//  2. op_a=16'hFFFF, op_b=16'h0001, cin=0 -> sum=16'h0000, cout=1 (carry ripples all nibbles).
//  3. op_a=16'hFFFF, op_b=16'h0000, cin=1 -> sum=16'h0000, cout=1; op_a=16'h0F0F,
//     op_b=16'h00F1, cin=0 -> sum=16'h1000, cout=0 (inter-nibble carry chain).
//  4. res_ready held 0 for 6 cycles in DONE; start_valid=1 throughout -> sum/cout stable,
//     start_ready=0, no new capture; res_ready=1 -> IDLE next edge, then new op accepted.
//  5. Change op_a/op_b every cycle during ADD -> result equals sum of values at accept edge.
//  6. Assert rst_n=0 during 2nd ADD cycle -> res_valid=0, sum=0, cout=0, busy=0 immediately;
//     after release, op 16'h0001+16'h0001 -> sum=16'h0002, cout=0.

Source files
------------

// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared constants for the nibble-serial adder slice.
// Nibble width and the FSM state encodings.
package nibble_serial_add_ctrl_pkg;
  localparam int NIBBLE_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// Request/result handshake bundle for the serial adder.
// The requester and consumer drive the master side.
interface nibble_serial_add_ctrl_if #(
  parameter int W = 16
);
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  modport master (
    output start_valid, op_a, op_b, cin, res_ready,
    input  start_ready, res_valid, sum, cout, busy
  );

  modport slave (
    input  start_valid, op_a, op_b, cin, res_ready,
    output start_ready, res_valid, sum, cout, busy
  );
endinterface

// File: rtl/nibble_serial_add_ctrl_ripple_adder.sv
// Combinational 4-bit ripple-carry adder slice.
// Shared by the sequencer for every nibble.
module ripple_adder
  import nibble_serial_add_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] X,
  input  logic [NIBBLE_W-1:0] Y,
  input  logic                Cin,
  output logic [NIBBLE_W-1:0] S,
  output logic                Co
);
  logic [NIBBLE_W:0] c;

  // Ripple the carry bit by bit through the slice.
  always_comb begin
    c    = '0;
    S    = '0;
    c[0] = Cin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      S[i]   = X[i] ^ Y[i] ^ c[i];
      c[i+1] = (X[i] & Y[i]) | (c[i] & (X[i] ^ Y[i]));
    end
    Co = c[NIBBLE_W];
  end
endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Wide adder run one nibble per cycle, LSB first,
// through a single shared ripple_adder slice.
module nibble_serial_add_ctrl
  import nibble_serial_add_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  nibble_serial_add_ctrl_if.slave  bus
);
  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  logic [1:0]          state;
  logic [W-1:0]        a_sh;
  logic [W-1:0]        b_sh;
  logic [W-1:0]        sum_q;
  logic                cout_q;
  logic                carry;
  logic [IW-1:0]       idx;
  logic [NIBBLE_W-1:0] s_nib;
  logic                co;
  logic [W+3:0]        sum_cat;

  ripple_adder u_add (
    .X   (a_sh[NIBBLE_W-1:0]),
    .Y   (b_sh[NIBBLE_W-1:0]),
    .S   (s_nib),
    .Co  (co),
    .Cin (carry)
  );

  // New nibble enters at the top; the sum register shifts down.
  assign sum_cat = {s_nib, sum_q};

  assign bus.start_ready = (state == ST_IDLE);
  assign bus.res_valid   = (state == ST_DONE);
  assign bus.busy        = (state != ST_IDLE);
  assign bus.sum         = sum_q;
  assign bus.cout        = cout_q;

  // Sequencer: capture operands, step nibbles, hold result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      carry  <= 1'b0;
      idx    <= '0;
    end else begin
      unique case (1'b1)
        (state == ST_IDLE): begin
          if (bus.start_valid) begin
            a_sh  <= bus.op_a;
            b_sh  <= bus.op_b;
            carry <= bus.cin;
            idx   <= '0;
            sum_q <= '0;
            state <= ST_ADD;
          end
        end
        (state == ST_ADD): begin
          a_sh  <= a_sh >> NIBBLE_W;
          b_sh  <= b_sh >> NIBBLE_W;
          sum_q <= sum_cat[W+3:4];
          carry <= co;
          idx   <= idx + 1'b1;
          if (idx == LAST) begin
            cout_q <= co;
            state  <= ST_DONE;
          end
        end
        (state == ST_DONE): begin
          if (bus.res_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
